// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets one of four requesters
// stream a burst of beats into the write side of a FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick the next valid requester round-robin
// ST_BURST | grant_id owns the FIFO write port until last beat or
//          | MAX_BURST beats, stalling on its valid low or fifo_full
//
// Round-robin pointer: r_last_grant holds the owner of the most recently
// finished burst; the search starts one past it, so a requester that just
// finished has the lowest priority. Reset sets it to 3 so requester 0 wins
// first.

module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    input  logic                fifo_full,
    output logic                fifo_w_en,
    output logic [DW-1:0]       fifo_wdata,
    output logic [1:0]          grant_id,
    output logic                busy
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_grant_id;
    logic [1:0]        r_last_grant;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [1:0]        w_pick;
    logic              w_pick_vld;
    logic              w_start;
    logic              w_g_valid;
    logic              w_g_last;
    logic              w_xfer;
    logic              w_burst_end;
    logic [DW-1:0]     w_wdata;
    logic [NREQ-1:0]   w_ready;

    // Round-robin search starting one past the last finished owner; the
    // 2-bit index wraps so offset 4 lands back on r_last_grant itself.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_pick_vld && req_valid[r_last_grant + 2'(k)]) begin
                w_pick     = r_last_grant + 2'(k);
                w_pick_vld = 1'b1;
            end
        end
    end

    // Select the granted requester's valid, last and data.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_wdata   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == 2'(i)) begin
                w_g_valid = req_valid[i];
                w_g_last  = req_last[i];
                w_wdata   = req_data[i*DW +: DW];
            end
        end
    end

    // A beat moves only for the owner, only while the FIFO has room, and
    // never on a reset edge so an aborted burst cannot leak one more write.
    assign w_start     = (r_state == ST_IDLE) && w_pick_vld;
    assign w_xfer      = (r_state == ST_BURST) && w_g_valid && !fifo_full && !rst;
    assign w_burst_end = w_xfer && (w_g_last || (r_beat_cnt == LAST_BEAT));

    // Next-state decode for the two-state FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_burst_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-requester ready: only the owner, only in BURST, only when not full.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = (r_state == ST_BURST) && (r_grant_id == 2'(i)) &&
                         !fifo_full && !rst;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is latched at arbitration; the round-robin pointer moves at burst end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id   <= 2'd0;
            r_last_grant <= 2'd3;
        end else begin
            if (w_start) begin
                r_grant_id <= w_pick;
            end
            if (w_burst_end) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    // Beat counter: cleared entering and leaving a burst, counts transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_start || w_burst_end) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign req_ready  = w_ready;
    assign fifo_w_en  = w_xfer;
    assign fifo_wdata = w_wdata;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with hand-computed expectations.

module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_w_en;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        grant_id;
    logic              busy;

    logic [31:0] dat [4] = '{32'hD0D0_0000, 32'hD1D1_0001, 32'hD2D2_0002, 32'hD3D3_0003};

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] obs;
    logic [7:0] exp_v;

    // Packed view: {busy, grant_id[1:0], req_ready[3:0], fifo_w_en}
    assign obs      = {busy, grant_id, req_ready, fifo_w_en};
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_w_en  (fifo_w_en),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    function automatic logic [7:0] ev(input logic b, input logic [1:0] g,
                                      input logic [3:0] r, input logic w);
        return {b, g, r, w};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        fifo_full = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        fifo_full = 1'b0;
        cyc();
        cyc();
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold: got {busy,gid,rdy,wen}=%b expected %b", obs, exp_v);
        end
        rst       = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL idle_no_req c%0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g;
        logic [1:0] g_prev;
        do_reset();
        req_valid = 4'b1111;
        g_prev    = 2'd0;
        for (int b = 0; b < 5; b++) begin
            g = 2'(b % 4);
            #1;
            exp_v = ev(1'b0, g_prev, 4'b0000, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_idle b%0d: got %b expected %b", b, obs, exp_v);
            end
            cyc();
            for (int c = 0; c < 4; c++) begin
                #1;
                exp_v = ev(1'b1, g, 4'(1 << g), 1'b1);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rr_beat b%0d c%0d: got %b expected %b", b, c, obs, exp_v);
                end
                n_checks++;
                if (fifo_wdata !== dat[g]) begin
                    n_fail++;
                    $display("FAIL rr_data b%0d c%0d: got %h expected %h", b, c, fifo_wdata, dat[g]);
                end
                cyc();
            end
            g_prev = g;
        end
        req_valid = 4'b0000;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rr_final_idle: got %b expected %b", obs, exp_v);
        end
        cyc();
    endtask

    task automatic test_last();
        int n_wen;
        n_wen = 0;
        do_reset();
        req_valid = 4'b0100;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL last_idle: got %b expected %b", obs, exp_v);
        end
        cyc();
        for (int c = 0; c < 2; c++) begin
            req_last = (c == 1) ? 4'b0100 : 4'b0000;
            #1;
            if (fifo_w_en === 1'b1) n_wen++;
            exp_v = ev(1'b1, 2'd2, 4'b0100, 1'b1);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL last_beat c%0d: got %b expected %b", c, obs, exp_v);
            end
            n_checks++;
            if (fifo_wdata !== dat[2]) begin
                n_fail++;
                $display("FAIL last_data c%0d: got %h expected %h", c, fifo_wdata, dat[2]);
            end
            cyc();
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (fifo_w_en === 1'b1) n_wen++;
            exp_v = ev(1'b0, 2'd2, 4'b0000, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL last_after c%0d: got %b expected %b", c, obs, exp_v);
            end
            cyc();
        end
        n_checks++;
        if (n_wen !== 2) begin
            n_fail++;
            $display("FAIL last_wen_count: got %0d expected 2", n_wen);
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0001;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL full_idle: got %b expected %b", obs, exp_v);
        end
        cyc();
        #1;
        exp_v = ev(1'b1, 2'd0, 4'b0001, 1'b1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL full_beat1: got %b expected %b", obs, exp_v);
        end
        cyc();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_v = ev(1'b1, 2'd0, 4'b0000, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL full_stall c%0d: got %b expected %b", c, obs, exp_v);
            end
            cyc();
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_v = ev(1'b1, 2'd0, 4'b0001, 1'b1);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL full_resume c%0d: got %b expected %b", c, obs, exp_v);
            end
            n_checks++;
            if (fifo_wdata !== dat[0]) begin
                n_fail++;
                $display("FAIL full_data c%0d: got %h expected %h", c, fifo_wdata, dat[0]);
            end
            cyc();
        end
        req_valid = 4'b0000;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL full_done: got %b expected %b", obs, exp_v);
        end
        cyc();
    endtask

    task automatic test_valid_stall();
        do_reset();
        req_valid = 4'b0011;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL vstall_idle: got %b expected %b", obs, exp_v);
        end
        cyc();
        #1;
        exp_v = ev(1'b1, 2'd0, 4'b0001, 1'b1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL vstall_beat1: got %b expected %b", obs, exp_v);
        end
        cyc();
        req_valid = 4'b0010;
        req_last  = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            #1;
            exp_v = ev(1'b1, 2'd0, 4'b0001, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL vstall_hold c%0d: got %b expected %b", c, obs, exp_v);
            end
            cyc();
        end
        req_valid = 4'b0011;
        req_last  = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_v = ev(1'b1, 2'd0, 4'b0001, 1'b1);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL vstall_resume c%0d: got %b expected %b", c, obs, exp_v);
            end
            cyc();
        end
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL vstall_end_idle: got %b expected %b", obs, exp_v);
        end
        cyc();
        #1;
        exp_v = ev(1'b1, 2'd1, 4'b0010, 1'b1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL vstall_next_grant: got %b expected %b", obs, exp_v);
        end
        n_checks++;
        if (fifo_wdata !== dat[1]) begin
            n_fail++;
            $display("FAIL vstall_next_data: got %h expected %h", fifo_wdata, dat[1]);
        end
        req_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b1000;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_idle: got %b expected %b", obs, exp_v);
        end
        cyc();
        #1;
        exp_v = ev(1'b1, 2'd3, 4'b1000, 1'b1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_beat1: got %b expected %b", obs, exp_v);
        end
        n_checks++;
        if (fifo_wdata !== dat[3]) begin
            n_fail++;
            $display("FAIL rmid_data: got %h expected %h", fifo_wdata, dat[3]);
        end
        cyc();
        rst = 1'b1;
        #1;
        exp_v = ev(1'b1, 2'd3, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_during_rst: got %b expected %b", obs, exp_v);
        end
        cyc();
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        exp_v = ev(1'b0, 2'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_after_rst: got %b expected %b", obs, exp_v);
        end
        cyc();
        #1;
        exp_v = ev(1'b1, 2'd0, 4'b0001, 1'b1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_regrant: got %b expected %b", obs, exp_v);
        end
        req_valid = 4'b0000;
        cyc();
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        fifo_full = 1'b0;
        test_reset();
        test_back_to_back();
        test_last();
        test_full_stall();
        test_valid_stall();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (fixed at 4 in this revision).
REQ-002 Parameter DW, default 32, data width, matching the FIFO write data port.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant (power of two, 2..16).
REQ-004 clk  input  1  single clock; same domain as the FIFO write side.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester data-valid.
REQ-007 req_data  input  NREQ*DW  requester i data on bits [DW*i+DW-1 : DW*i].
REQ-008 req_last  input  NREQ  per-requester end-of-burst marker, qualified by valid.
REQ-009 req_ready  output  NREQ  per-requester accept.
REQ-010 fifo_full  input  1  FIFO full flag, write domain.
REQ-011 fifo_w_en  output  1  FIFO write enable.
REQ-012 fifo_wdata  output  DW  FIFO write data.
REQ-013 grant_id  output  2  index of the currently or last granted requester.
REQ-014 busy  output  1  high while in the BURST state.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-016 In IDLE with any req_valid high, the arbiter SHALL pick the first valid requester searching round-robin from (last_grant+1) mod 4, register it in grant_id, and enter BURST on the next clock; arbitration latency is 1 cycle.
REQ-017 In IDLE with no req_valid high, the FSM SHALL remain in IDLE with grant_id unchanged.
REQ-018 req_ready[i] SHALL be combinational and equal (state==BURST) & (grant_id==i) & ~fifo_full; all other ready bits SHALL be 0.
REQ-019 A transfer occurs when req_valid[g] & req_ready[g] for granted index g.
REQ-020 fifo_w_en SHALL equal the transfer condition, and fifo_wdata SHALL equal req_data slice g (combinational mux), so the FIFO never sees w_en while fifo_full is high.
REQ-021 A beat counter SHALL clear on entry to BURST and increment by 1 per transfer.
REQ-022 BURST SHALL exit to IDLE after a transfer that has req_last[g]=1, or whose beat count reaches MAX_BURST (counter value MAX_BURST-1 before the increment), whichever comes first.
REQ-023 On BURST exit, last_grant SHALL be set to g.
REQ-024 In BURST, deassertion of req_valid[g] SHALL stall the arbiter: grant held, no transfer, counter unchanged.
REQ-025 fifo_full high SHALL stall the arbiter identically; the burst resumes on the first cycle full is low.
REQ-026 Requests from non-granted requesters during BURST SHALL be ignored until the FSM returns to IDLE.
REQ-027 Back-to-back bursts SHALL have exactly one IDLE cycle between them (no transfers in IDLE).
REQ-028 req_last asserted with valid low SHALL have no effect.

Reset
REQ-029 While rst is high at a clk edge, the FSM SHALL enter IDLE, and grant_id, beat counter and busy SHALL reset to 0.
REQ-030 On reset, last_grant SHALL reset to 3, so requester 0 wins first.
REQ-031 During and after reset, fifo_w_en and all req_ready bits SHALL be 0 until a new grant.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no further write on that edge or after.

Verification
REQ-033 Reset, then req_valid=4'b1111 held, last never set, fifo_full=0 -> grants 0,1,2,3,0 in order; each burst is 4 beats, followed by 1 IDLE cycle.
REQ-034 Only requester 2 valid, req_last on beat 2 -> exactly 2 fifo_w_en pulses with its data; busy falls the next cycle; grant_id stays 2.
REQ-035 During a burst, fifo_full=1 for 3 cycles -> req_ready and fifo_w_en are 0 for those cycles; the beat count is preserved and the burst completes after full drops.
REQ-036 Granted requester drops valid for 2 cycles while requester 1 is valid -> grant held with no transfers; requester 1 is granted only after the current burst ends.
REQ-037 rst pulsed on beat 2 of a burst by requester 3 -> next cycle IDLE with grant_id=0 and w_en=0; the next arbitration with all valid grants requester 0.
